// File: rtl/stopwatch_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : stopwatch_pkg                                                |
// | Description : Shared types and helpers for the stopwatch lap timer:        |
// |               FSM state encoding, BCD digit width, per-digit radix and     |
// |               prescaler divide ratio.                                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package stopwatch_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  // Digit order is cs, cs, s, 10s, min, 10min, h, 10h: the tens-of-seconds
  // and tens-of-minutes positions roll over at 6, everything else at 10.
  function automatic int digit_radix(input int k);
    return ((k == 3) || (k == 5)) ? 6 : 10;
  endfunction

  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_cell.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bcd_digit_cell                                               |
// | Description : One mod-RADIX BCD digit. Advances when inc_en and carry_in   |
// |               are both high; carry_out is purely combinational so a whole  |
// |               chain of cells ripples within one clock.                     |
// | Revision    : 1.0 - initial release                                        |
// | Ports       : clk       - system clock                                     |
// |               clear     - synchronous clear to 0 (highest priority)        |
// |               inc_en    - count enable (one prescaler tick)                |
// |               carry_in  - lower digits are all at maximum                  |
// |               carry_out - carry_in and this digit at RADIX-1               |
// |               digit     - current BCD value                                |
// +----------------------------------------------------------------------------+
module bcd_digit_cell
  import stopwatch_pkg::*;
#(
  parameter int RADIX = 10
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               inc_en,
  input  logic               carry_in,
  output logic               carry_out,
  output logic [DIGIT_W-1:0] digit
);

  localparam logic [DIGIT_W-1:0] DIGIT_MAX = DIGIT_W'(RADIX - 1);

  logic at_max;

  assign at_max    = (digit == DIGIT_MAX);
  assign carry_out = carry_in & at_max;

  always_ff @(posedge clk) begin
    if (clear) begin
      digit <= '0;
    end else if (inc_en && carry_in) begin
      digit <= at_max ? '0 : digit + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/stopwatch_lap_timer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : stopwatch_lap_timer                                          |
// | Description : BCD stopwatch with start/pause/resume, lap freeze of the     |
// |               displayed value and a sticky full-scale overflow flag.       |
// |               Optional input debounce enabled by defining the macro        |
// |               STOPWATCH_DEBOUNCE_EN.                                       |
// | Revision    : 1.0 - initial release                                        |
// | Ports       : clk        - system clock                                    |
// |               hard_reset - sync active-high, resets every register         |
// |               soft_reset - sync active-high, clears time/flags, to IDLE    |
// |               start      - level; each rising edge toggles run/pause       |
// |               lap        - level; each rising edge toggles lap freeze      |
// |               digits     - displayed BCD value, digit k at [4k+3:4k]       |
// |               running    - 1 while counting                                |
// |               lap_active - 1 while the display is frozen                   |
// |               overflow   - sticky full-scale wrap flag                     |
// +----------------------------------------------------------------------------+
module stopwatch_lap_timer
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ          = 50000000,
  parameter int TICK_HZ         = 100,
  parameter int NUM_DIGITS      = 6,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                    clk,
  input  logic                    hard_reset,
  input  logic                    soft_reset,
  input  logic                    start,
  input  logic                    lap,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    running,
  output logic                    lap_active,
  output logic                    overflow
);

  localparam int              DIV        = calc_div(CLK_HZ, TICK_HZ);
  localparam int              PW         = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(DIV - 1);

  // ---------------------------------------------------------------------------
  // Input synchroniser; bit 0 = start, bit 1 = lap. Only hard_reset clears it
  // so a soft reset does not fabricate or lose an edge.
  // ---------------------------------------------------------------------------
  logic [1:0] sync_q;
  logic [1:0] sync_qq;
  logic [1:0] edge_det;
  logic       start_edge;
  logic       lap_edge;

  always_ff @(posedge clk) begin
    if (hard_reset) begin
      sync_q  <= '0;
      sync_qq <= '0;
    end else begin
      sync_q  <= {lap, start};
      sync_qq <= sync_q;
    end
  end

`ifdef STOPWATCH_DEBOUNCE_EN
  localparam int             DBW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

  for (genvar i = 0; i < 2; i++) begin : g_debounce
    logic [DBW-1:0] db_cnt;
    logic           filt;

    // The counter tracks how long the synced level has disagreed with the
    // filtered level; any agreeing sample restarts the run.
    always_ff @(posedge clk) begin
      if (hard_reset) begin
        db_cnt <= '0;
        filt   <= 1'b0;
      end else if (sync_qq[i] == filt) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_cnt <= '0;
        filt   <= sync_qq[i];
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end

    // Rising edge of the filtered level, flagged in the cycle it is accepted.
    assign edge_det[i] = sync_qq[i] & ~filt & (db_cnt == DB_LAST);
  end
`else
  assign edge_det = sync_q & ~sync_qq;
`endif

  assign start_edge = edge_det[0];
  assign lap_edge   = edge_det[1];

  // ---------------------------------------------------------------------------
  // Run/pause FSM and lap decisions, all against the pre-edge state
  // ---------------------------------------------------------------------------
  state_t state;
  state_t state_next;
  logic   lap_latch;
  logic   lap_clear;

  always_ff @(posedge clk) begin
    if (hard_reset || soft_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    running    = 1'b0;
    lap_latch  = 1'b0;
    lap_clear  = 1'b0;
    case (state)
      IDLE: begin
        if (start_edge) state_next = RUN;
      end
      RUN: begin
        running = 1'b1;
        if (start_edge) state_next = PAUSE;
      end
      PAUSE: begin
        if (start_edge) state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
    if (lap_edge) begin
      if (lap_active) begin
        lap_clear = 1'b1;
      end else if (state == RUN) begin
        lap_latch = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Prescaler: holds its value while paused so resume continues mid-period
  // ---------------------------------------------------------------------------
  logic [PW-1:0] presc;
  logic          tick;

  assign tick = running && (presc == PRESC_LAST);

  always_ff @(posedge clk) begin
    if (hard_reset || soft_reset) begin
      presc <= '0;
    end else if (running) begin
      presc <= tick ? '0 : presc + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // BCD digit chain; carry[NUM_DIGITS] high means every digit is at maximum
  // ---------------------------------------------------------------------------
  logic [NUM_DIGITS:0]     carry;
  logic [4*NUM_DIGITS-1:0] count;
  logic                    clear_all;

  assign carry[0]  = 1'b1;
  assign clear_all = hard_reset | soft_reset;

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    bcd_digit_cell #(
      .RADIX (digit_radix(k))
    ) u_cell (
      .clk       (clk),
      .clear     (clear_all),
      .inc_en    (tick),
      .carry_in  (carry[k]),
      .carry_out (carry[k+1]),
      .digit     (count[DIGIT_W*k +: DIGIT_W])
    );
  end

  // ---------------------------------------------------------------------------
  // Lap register and sticky overflow
  // ---------------------------------------------------------------------------
  logic [4*NUM_DIGITS-1:0] lap_reg;

  always_ff @(posedge clk) begin
    if (hard_reset || soft_reset) begin
      lap_reg    <= '0;
      lap_active <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (lap_latch) begin
        lap_reg    <= count;
        lap_active <= 1'b1;
      end else if (lap_clear) begin
        lap_active <= 1'b0;
      end
      if (tick && carry[NUM_DIGITS]) begin
        overflow <= 1'b1;
      end
    end
  end

  assign digits = lap_active ? lap_reg : count;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_lap_timer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_stopwatch_lap_timer                                       |
// | Description : Self-checking bench for stopwatch_lap_timer. Main instance   |
// |               runs at DIV=10 with 6 digits; two auxiliary instances at     |
// |               DIV=2 (6 and 4 digits) reach the minute carry and the        |
// |               full-scale wrap in a short run.                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_stopwatch_lap_timer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic        hard_reset = 1'b0;
  logic        soft_reset = 1'b0;
  logic        start      = 1'b0;
  logic        lap        = 1'b0;
  logic [23:0] digits;
  logic        running, lap_active, overflow;

  stopwatch_lap_timer #(
    .CLK_HZ          (1000),
    .TICK_HZ         (100),
    .NUM_DIGITS      (6),
    .DEBOUNCE_CYCLES (4)
  ) u_dut (
    .clk        (clk),
    .hard_reset (hard_reset),
    .soft_reset (soft_reset),
    .start      (start),
    .lap        (lap),
    .digits     (digits),
    .running    (running),
    .lap_active (lap_active),
    .overflow   (overflow)
  );

  // auxiliary instances share their inputs
  logic        a_hard  = 1'b1;
  logic        a_soft  = 1'b0;
  logic        a_start = 1'b0;
  logic        a_lap   = 1'b0;
  logic [23:0] b_digits;
  logic        b_run, b_lap, b_ovf;
  logic [15:0] c_digits;
  logic        c_run, c_lap, c_ovf;

  stopwatch_lap_timer #(
    .CLK_HZ          (200),
    .TICK_HZ         (100),
    .NUM_DIGITS      (6),
    .DEBOUNCE_CYCLES (4)
  ) u_aux6 (
    .clk        (clk),
    .hard_reset (a_hard),
    .soft_reset (a_soft),
    .start      (a_start),
    .lap        (a_lap),
    .digits     (b_digits),
    .running    (b_run),
    .lap_active (b_lap),
    .overflow   (b_ovf)
  );

  stopwatch_lap_timer #(
    .CLK_HZ          (200),
    .TICK_HZ         (100),
    .NUM_DIGITS      (4),
    .DEBOUNCE_CYCLES (4)
  ) u_aux4 (
    .clk        (clk),
    .hard_reset (a_hard),
    .soft_reset (a_soft),
    .start      (a_start),
    .lap        (a_lap),
    .digits     (c_digits),
    .running    (c_run),
    .lap_active (c_lap),
    .overflow   (c_ovf)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
    end
  endtask

  typedef struct {
    logic        st;
    logic        lp;
    logic        sr;
    logic        hr;
    int          cyc;
    logic [23:0] dig;
    logic        run;
    logic        lpa;
    logic        ovf;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic st, input logic lp, input logic sr, input logic hr,
                     input int cyc, input logic [23:0] dig, input logic run,
                     input logic lpa, input logic ovf);
    vec_t v;
    v.st = st; v.lp = lp; v.sr = sr; v.hr = hr; v.cyc = cyc;
    v.dig = dig; v.run = run; v.lpa = lpa; v.ovf = ovf;
    tbl.push_back(v);
  endtask

  initial begin
    //   st lp sr hr  cyc  digits      run lpa ovf
    add(1'b0,1'b0,1'b0,1'b1,   1, 24'h000000, 1'b0,1'b0,1'b0); // hard reset
    add(1'b0,1'b0,1'b0,1'b0,   2, 24'h000000, 1'b0,1'b0,1'b0); // idle
    add(1'b1,1'b0,1'b0,1'b0,   1, 24'h000000, 1'b0,1'b0,1'b0); // 1 cycle: not yet
    add(1'b1,1'b0,1'b0,1'b0,   1, 24'h000000, 1'b1,1'b0,1'b0); // 2 cycles: RUN
    add(1'b0,1'b0,1'b0,1'b0, 250, 24'h000025, 1'b1,1'b0,1'b0); // 25 ticks
    add(1'b0,1'b0,1'b0,1'b0,  50, 24'h000030, 1'b1,1'b0,1'b0); // 00.30
    add(1'b0,1'b1,1'b0,1'b0,   1, 24'h000030, 1'b1,1'b0,1'b0); // lap sync
    add(1'b0,1'b0,1'b0,1'b0,   1, 24'h000030, 1'b1,1'b1,1'b0); // lap latched
    add(1'b0,1'b0,1'b0,1'b0, 100, 24'h000030, 1'b1,1'b1,1'b0); // frozen, live=40
    add(1'b0,1'b1,1'b0,1'b0,   1, 24'h000030, 1'b1,1'b1,1'b0); // 2nd lap sync
    add(1'b0,1'b0,1'b0,1'b0,   1, 24'h000040, 1'b1,1'b0,1'b0); // live shown
    add(1'b1,1'b1,1'b0,1'b0,   1, 24'h000040, 1'b1,1'b0,1'b0); // both edges sync
    add(1'b0,1'b0,1'b0,1'b0,   1, 24'h000040, 1'b0,1'b1,1'b0); // PAUSE + lap
    add(1'b0,1'b0,1'b0,1'b0,  50, 24'h000040, 1'b0,1'b1,1'b0); // frozen in pause
    add(1'b0,1'b1,1'b0,1'b0,   1, 24'h000040, 1'b0,1'b1,1'b0); // lap sync
    add(1'b0,1'b0,1'b0,1'b0,   1, 24'h000040, 1'b0,1'b0,1'b0); // live count held
    add(1'b1,1'b0,1'b0,1'b0,   1, 24'h000040, 1'b0,1'b0,1'b0); // resume sync
    add(1'b0,1'b0,1'b0,1'b0,   1, 24'h000040, 1'b1,1'b0,1'b0); // RUN, presc=6
    add(1'b0,1'b0,1'b0,1'b0,   3, 24'h000040, 1'b1,1'b0,1'b0); // presc 9
    add(1'b0,1'b0,1'b0,1'b0,   1, 24'h000041, 1'b1,1'b0,1'b0); // tick
    add(1'b1,1'b0,1'b0,1'b0,   1, 24'h000041, 1'b1,1'b0,1'b0); // start sync
    add(1'b1,1'b0,1'b1,1'b0,   1, 24'h000000, 1'b0,1'b0,1'b0); // soft beats edge
    add(1'b0,1'b0,1'b0,1'b0,   3, 24'h000000, 1'b0,1'b0,1'b0); // stays IDLE
    add(1'b0,1'b1,1'b0,1'b0,   1, 24'h000000, 1'b0,1'b0,1'b0); // lap in IDLE
    add(1'b0,1'b0,1'b0,1'b0,   1, 24'h000000, 1'b0,1'b0,1'b0); // ignored
    add(1'b1,1'b0,1'b0,1'b0,   1, 24'h000000, 1'b0,1'b0,1'b0); // start sync
    add(1'b0,1'b0,1'b0,1'b0,   1, 24'h000000, 1'b1,1'b0,1'b0); // RUN
    add(1'b0,1'b0,1'b0,1'b0,  30, 24'h000003, 1'b1,1'b0,1'b0); // 3 ticks
    add(1'b0,1'b1,1'b0,1'b0,   1, 24'h000003, 1'b1,1'b0,1'b0); // lap sync
    add(1'b0,1'b0,1'b0,1'b0,   1, 24'h000003, 1'b1,1'b1,1'b0); // mid-lap
    add(1'b0,1'b0,1'b0,1'b1,   1, 24'h000000, 1'b0,1'b0,1'b0); // hard reset
    add(1'b0,1'b0,1'b0,1'b0,  20, 24'h000000, 1'b0,1'b0,1'b0); // stays clear

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      start      = tbl[i].st;
      lap        = tbl[i].lp;
      soft_reset = tbl[i].sr;
      hard_reset = tbl[i].hr;
      repeat (tbl[i].cyc) @(negedge clk);
      chk("digits",     i, {8'h00, digits},    {8'h00, tbl[i].dig});
      chk("running",    i, {31'd0, running},   {31'd0, tbl[i].run});
      chk("lap_active", i, {31'd0, lap_active}, {31'd0, tbl[i].lpa});
      chk("overflow",   i, {31'd0, overflow},  {31'd0, tbl[i].ovf});
    end

    // Auxiliary run at DIV=2: count k appears 2+2k cycles after start edge
    a_hard = 1'b0;
    chk("aux6_reset", 100, {8'h00, b_digits}, 32'h0);
    chk("aux4_reset", 100, {16'h0, c_digits}, 32'h0);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    repeat (11999) @(negedge clk);
    // 5999 ticks: 0:59.99 / 59.99
    chk("aux6_5999",  101, {8'h00, b_digits}, 32'h005999);
    chk("aux4_5999",  101, {16'h0, c_digits}, 32'h5999);
    chk("aux4_ovf0",  101, {31'd0, c_ovf},    32'h0);
    @(negedge clk);
    chk("aux6_hold",  102, {8'h00, b_digits}, 32'h005999);
    @(negedge clk);
    // 6000 ticks: minute carry on 6 digits, full-scale wrap on 4 digits
    chk("aux6_min",   103, {8'h00, b_digits}, 32'h010000);
    chk("aux6_ovf",   103, {31'd0, b_ovf},    32'h0);
    chk("aux4_wrap",  103, {16'h0, c_digits}, 32'h0000);
    chk("aux4_ovf1",  103, {31'd0, c_ovf},    32'h1);
    chk("aux4_run",   103, {31'd0, c_run},    32'h1);
    repeat (2) @(negedge clk);
    chk("aux4_cont",  104, {16'h0, c_digits}, 32'h0001);
    chk("aux4_stick", 104, {31'd0, c_ovf},    32'h1);
    chk("aux6_cont",  104, {8'h00, b_digits}, 32'h010001);
    a_soft = 1'b1;
    @(negedge clk);
    a_soft = 1'b0;
    chk("aux4_sr_ovf", 105, {31'd0, c_ovf},    32'h0);
    chk("aux4_sr_run", 105, {31'd0, c_run},    32'h0);
    chk("aux4_sr_dig", 105, {16'h0, c_digits}, 32'h0);
    chk("aux6_sr_dig", 105, {8'h00, b_digits}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stopwatch_lap_timer.md
Name: stopwatch_lap_timer

Overview:
Parametrised next-generation stopwatch core. It counts elapsed time in BCD digits at a configurable tick rate, with any number of digits. Adds start/pause/resume, a lap (split) freeze of the displayed value, and a sticky overflow flag. Drives the existing seg_controller-style display mux through a flat digit bus.

Parameters:
CLK_HZ, 50000000, input clock frequency
TICK_HZ, 100, count rate (100 = hundredths of a second); DIV = CLK_HZ/TICK_HZ, must be an integer >= 2
NUM_DIGITS, 6, number of BCD digits, 4..8
DEBOUNCE_CYCLES, 1000000, stable cycles required by the debounce filter (only with STOPWATCH_DEBOUNCE_EN)

Ports:
clk  in  1  system clock
hard_reset  in  1  synchronous, active-high; full reset of every register
soft_reset  in  1  synchronous, active-high; clears the time, returns to IDLE
start  in  1  level input; each rising edge toggles run/pause
lap  in  1  level input; each rising edge toggles lap freeze
digits  out  4*NUM_DIGITS  displayed BCD value; digit k at bits [4k+3:4k]; digit 0 = least significant
running  out  1  1 while counting
lap_active  out  1  1 while the displayed value is frozen
overflow  out  1  sticky; set on full-scale wrap

Behaviour:
- One clock: clk. hard_reset is synchronous, active-high.
- Reset values (hard_reset): digits=0, running=0, lap_active=0, overflow=0, prescaler=0, state=IDLE, all sync/edge flops=0.
- Input path: start and lap are each registered twice (q, qq). An edge is defined as q=1 and qq=0. A level rising before edge k produces state change visible after edge k+1 (2-cycle latency).
- Radix: digits 3 and 5 are mod-6; all other digits are mod-10 (cs, cs, s, 10s, min, 10min, h, 10h).
- Prescaler: counts 0..DIV-1 only while running. At DIV-1 it wraps to 0 and the counter increments at that same edge, so the first increment comes DIV cycles after running rises. Pause holds the prescaler value; resume continues from it.
- Carry ripples combinationally across all digits within one cycle.
- Overflow: when all digits are at maximum and a tick occurs, all digits wrap to 0 and overflow is set. Overflow stays set until soft_reset or hard_reset. Counting continues.
- FSM states: IDLE, RUN, PAUSE.
  - IDLE + start edge -> RUN
  - RUN + start edge -> PAUSE
  - PAUSE + start edge -> RUN
  - running=1 only in RUN.
- Lap:
  - In RUN, a lap edge with lap_active=0 latches the current count into the display register and sets lap_active. The internal count keeps running.
  - A lap edge with lap_active=1, in any state, clears it; the display then tracks the live count in the same cycle.
  - A lap edge in IDLE or PAUSE with lap_active=0 is ignored.
- digits = lap register if lap_active, otherwise the live count.
- Simultaneous start and lap edges: both are evaluated against the pre-edge state. Example: RUN with both edges -> PAUSE and lap latched.
- soft_reset: count=0, prescaler=0, state=IDLE, lap_active=0, overflow=0. Sync flops are kept. It beats any same-cycle edge.
- hard_reset beats everything, including mid-count and mid-lap.

Optional Feature:
STOPWATCH_DEBOUNCE_EN:
- Defined: each input gets a debounce counter after the 2-flop sync. The filtered level changes only after DEBOUNCE_CYCLES consecutive equal samples; the edge is taken on the filtered level. Latency = 2 + DEBOUNCE_CYCLES cycles. Counters reset to 0 on hard_reset.
- Undefined: no filter; 2-cycle latency as above. The DEBOUNCE_CYCLES parameter is unused.

Decomposition:
- Package stopwatch_pkg:
  - state enum (IDLE, RUN, PAUSE)
  - function digit_radix(k) returning 6 or 10
  - function calc_div(CLK_HZ, TICK_HZ)
  - BCD digit width constant (4)
- Sub-module bcd_digit_cell: one mod-RADIX digit with clear, inc-enable, carry_in and carry_out (carry_out = carry_in and digit==RADIX-1). Instantiated NUM_DIGITS times in a generate loop.

Test Plan:
- Bench parameters: CLK_HZ=1000, TICK_HZ=100 (DIV=10), NUM_DIGITS=6, macro undefined.
- Start pulse, run 250 cycles -> running=1 two cycles after start rises; digit1:digit0 = "25" (±1 tick at the boundary); digits 2..5 = 0.
- Preload by running to 0:00:59.99, one more tick -> digits = 0,0,0,0,1,0 (carry into minutes, digit 3 wraps mod-6); overflow=0.
- Count to 59:59.99, one tick -> all digits 0, overflow=1. soft_reset -> overflow=0, running=0.
- Lap at count 00.30, run 100 more cycles -> digits hold 00.30, lap_active=1. Second lap -> digits show 00.40 the same cycle lap_active drops.
- Start and lap edges in the same cycle while in RUN -> state PAUSE, lap_active=1. Further 50 cycles: frozen display; internal count unchanged.
- soft_reset and start asserted together mid-RUN -> IDLE, digits=0. hard_reset during RUN -> all outputs 0 next cycle.
